// File: rtl/mem_access_ctrl.sv
// Memory access controller: one outstanding load/store from the memory stage onto a simple ack bus.
// Optional bus timeout is compiled in when MEM_TIMEOUT_EN is defined (default build: no timeout).
//
// state | meaning
// IDLE  | no access in flight, accepts a new request
// BUSY  | bus strobe asserted from latched request, waiting for bus_ack
// DONE  | access finished, load_valid pulses for an unflushed read
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_data_o,
   input  logic [3:0]  mem_byte_en,
   input  logic [2:0]  mem_access_sz,
   input  logic        flag_unsigned,
   input  logic [31:0] reg_old,
   input  logic        alignment_err,
   input  logic        exception_flush,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   output logic        bus_rd,
   output logic        bus_wr,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        bus_err
);

   // Size codes must track the ACCESS_SZ_* values of the shared defs header.
   localparam logic [2:0] ACCESS_SZ_BYTE  = 3'd0;
   localparam logic [2:0] ACCESS_SZ_HALF  = 3'd1;
   localparam logic [2:0] ACCESS_SZ_WORD  = 3'd2;
   localparam logic [2:0] ACCESS_SZ_LEFT  = 3'd3;
   localparam logic [2:0] ACCESS_SZ_RIGHT = 3'd4;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [2:0]  sz_q;
   logic        uns_q;
   logic [31:0] old_q;
   logic        is_rd_q;
   logic        bus_rd_q;
   logic        bus_wr_q;
   logic        flush_q;
   logic [31:0] load_data_q;
   logic        load_valid_q;
   logic        bus_err_q;
`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'd254;
   logic [7:0]  cnt_q;
`endif

   logic        request;
   logic [1:0]  a;
   logic [4:0]  sh_left;
   logic [4:0]  sh_right;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] aligned_d;

   assign request = (mem_rd | mem_wr) & ~alignment_err & ~exception_flush;
   assign stall   = ((state_q == ST_IDLE) & request) | (state_q == ST_BUSY);

   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign bus_be     = be_q;
   assign bus_rd     = bus_rd_q;
   assign bus_wr     = bus_wr_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign bus_err    = bus_err_q;

   assign a = addr_q[1:0];

   always_comb begin
      sh_left   = {2'd3 - a, 3'b000};
      sh_right  = {a, 3'b000};
      rd_byte   = bus_rdata[{a, 3'b000} +: 8];
      rd_half   = bus_rdata[{a[1], 4'b0000} +: 16];
      aligned_d = bus_rdata;
      case (sz_q)
         ACCESS_SZ_BYTE:  aligned_d = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         ACCESS_SZ_HALF:  aligned_d = {{16{~uns_q & rd_half[15]}}, rd_half};
         ACCESS_SZ_WORD:  aligned_d = bus_rdata;
         ACCESS_SZ_LEFT:  aligned_d = (bus_rdata << sh_left) | (old_q & ~(32'hFFFF_FFFF << sh_left));
         ACCESS_SZ_RIGHT: aligned_d = (bus_rdata >> sh_right) | (old_q & ~(32'hFFFF_FFFF >> sh_right));
         default:         aligned_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         sz_q         <= '0;
         uns_q        <= 1'b0;
         old_q        <= '0;
         is_rd_q      <= 1'b0;
         bus_rd_q     <= 1'b0;
         bus_wr_q     <= 1'b0;
         flush_q      <= 1'b0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               flush_q <= 1'b0;
               if (request) begin
                  state_q  <= ST_BUSY;
                  addr_q   <= mem_address;
                  wdata_q  <= mem_data_o;
                  be_q     <= mem_byte_en;
                  sz_q     <= mem_access_sz;
                  uns_q    <= flag_unsigned;
                  old_q    <= reg_old;
                  // a simultaneous rd+wr request is treated as a read
                  is_rd_q  <= mem_rd;
                  bus_rd_q <= mem_rd;
                  bus_wr_q <= mem_wr & ~mem_rd;
`ifdef MEM_TIMEOUT_EN
                  cnt_q    <= '0;
`endif
               end
            end
            ST_BUSY: begin
               if (exception_flush) flush_q <= 1'b1;
               if (bus_ack) begin
                  state_q  <= ST_DONE;
                  bus_rd_q <= 1'b0;
                  bus_wr_q <= 1'b0;
                  if (is_rd_q) begin
                     load_data_q  <= aligned_d;
                     load_valid_q <= ~(flush_q | exception_flush);
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (cnt_q == TIMEOUT_LAST) begin
                  state_q     <= ST_DONE;
                  bus_rd_q    <= 1'b0;
                  bus_wr_q    <= 1'b0;
                  bus_err_q   <= 1'b1;
                  load_data_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
`endif
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports mem_rd, mem_wr  in  1 each  access request from memory stage.
REQ-004 SHALL have ports mem_address  in  32  byte address; mem_data_o  in  32  lane-replicated write data; mem_byte_en  in  4  lane enables.
REQ-005 SHALL have ports mem_access_sz  in  3  size code (ACCESS_SZ_* from shared defs header); flag_unsigned  in  1  zero-extend loads; reg_old  in  32  current destination value for LEFT/RIGHT merge.
REQ-006 SHALL have ports alignment_err, exception_flush  in  1 each  suppress new request.
REQ-007 SHALL have ports bus_addr  out  32; bus_wdata  out  32; bus_be  out  4; bus_rd, bus_wr  out  1 each; bus_rdata  in  32; bus_ack  in  1.
REQ-008 SHALL have ports stall  out  1  pipeline hold; load_data  out  32  aligned load result; load_valid  out  1  load_data valid; bus_err  out  1  timeout pulse.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 IDLE: request = (mem_rd|mem_wr) & ~alignment_err & ~exception_flush; if request, latch address, data, byte_en, size, flag_unsigned, reg_old, rd/wr, go BUSY.
REQ-011 stall SHALL be combinational: 1 in IDLE when request, 1 in BUSY, 0 in DONE.
REQ-012 BUSY: bus_rd/bus_wr, bus_addr, bus_wdata, bus_be SHALL be driven from latched values, stable until cycle bus_ack sampled high; in IDLE/DONE bus_rd=bus_wr=0, other bus outputs hold last latched value.
REQ-013 BUSY with bus_ack=1: for reads register aligned bus_rdata into load_data; go DONE; bus_ack outside BUSY SHALL be ignored.
REQ-014 DONE: load_valid=1 for exactly one cycle if latched access was read and not flushed; always return to IDLE; no new request accepted in DONE.
REQ-015 Minimum latency: request cycle N, bus strobe N+1, ack at N+1 -> DONE N+2, stall low N+2.
REQ-016 Alignment, a=addr[1:0]: BYTE -> rdata[8a+7:8a] sign/zero-extended per flag_unsigned; HALF -> rdata[16*addr[1]+15:16*addr[1]] extended; WORD -> rdata.
REQ-017 LEFT -> (rdata << 8*(3-a)) | (reg_old & low 8*(3-a) bits); a=3 gives rdata.
REQ-018 RIGHT -> (rdata >> 8a) | (reg_old & high 8a bits); a=0 gives rdata.
REQ-019 exception_flush during BUSY SHALL NOT abort bus cycle; set flush flag, complete on ack, suppress load_valid in DONE; flag clears in IDLE.
REQ-020 Writes SHALL never assert load_valid; load_data holds prior value.

Reset
REQ-021 rst asserted SHALL force IDLE immediately, clear flush flag, timeout counter, load_data=0, load_valid=0, bus_rd=bus_wr=0, bus_addr/bus_wdata=0, bus_be=0, bus_err=0.
REQ-022 rst mid-BUSY SHALL drop bus strobes asynchronously; late bus_ack after release ignored.

Configuration
REQ-023 With MEM_TIMEOUT_EN defined: 8-bit counter clears on BUSY entry, increments each BUSY cycle without ack; at 255 without ack, bus_err=1 one cycle, strobes drop, load_data=0, go DONE with load_valid suppressed.
REQ-024 Without MEM_TIMEOUT_EN: no counter, BUSY waits indefinitely, bus_err tied 0.

Verification
REQ-025 LW addr 0x100, ack after 3 cycles, rdata 0x89ABCDEF -> stall 4 cycles, load_data 0x89ABCDEF, load_valid one pulse.
REQ-026 LB signed addr 0x103, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102 rdata 0x8001xxxx -> 0xFFFF8001.
REQ-027 LWL addr 0x101 rdata 0x44332211 reg_old 0xAABBCCDD -> 0x2211CCDD; LWR addr 0x102 same data -> 0xAABB4433.
REQ-028 SW addr 0x200 data 0x12345678 be 1111, ack same cycle as strobe -> one bus_wr cycle, load_valid stays 0.
REQ-029 exception_flush in BUSY then ack -> bus cycle completes, load_valid 0; alignment_err with mem_rd in IDLE -> no strobe, stall 0.
REQ-030 rst mid-BUSY -> strobes 0 same cycle, IDLE; MEM_TIMEOUT_EN with no ack -> bus_err pulse on 255th BUSY cycle, return IDLE.
